// File: rtl/cpu_ctrl_pkg.sv
//------------------------------------------------------------------------------
// cpu_ctrl_pkg : shared encodings for the RV32I multi-cycle control unit
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_e;

    localparam logic [2:0] c_ST_IDLE    = ST_IDLE;
    localparam logic [2:0] c_ST_FETCH   = ST_FETCH;
    localparam logic [2:0] c_ST_DECODE  = ST_DECODE;
    localparam logic [2:0] c_ST_EXECUTE = ST_EXECUTE;
    localparam logic [2:0] c_ST_MEM     = ST_MEM;
    localparam logic [2:0] c_ST_WB      = ST_WB;
    localparam logic [2:0] c_ST_HALT    = ST_HALT;

    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    localparam logic [3:0] c_ALU_ADD    = 4'd0;
    localparam logic [3:0] c_ALU_SUB    = 4'd1;
    localparam logic [3:0] c_ALU_SLL    = 4'd2;
    localparam logic [3:0] c_ALU_SLT    = 4'd3;
    localparam logic [3:0] c_ALU_SLTU   = 4'd4;
    localparam logic [3:0] c_ALU_XOR    = 4'd5;
    localparam logic [3:0] c_ALU_SRL    = 4'd6;
    localparam logic [3:0] c_ALU_SRA    = 4'd7;
    localparam logic [3:0] c_ALU_OR     = 4'd8;
    localparam logic [3:0] c_ALU_AND    = 4'd9;
    localparam logic [3:0] c_ALU_PASS_B = 4'd10;

    localparam logic [1:0] c_PC_SRC_PC4  = 2'd0;
    localparam logic [1:0] c_PC_SRC_ALU  = 2'd1;
    localparam logic [1:0] c_PC_SRC_JALR = 2'd2;

    localparam logic [1:0] c_SRC_A_PC   = 2'd0;
    localparam logic [1:0] c_SRC_A_RS1  = 2'd1;
    localparam logic [1:0] c_SRC_A_ZERO = 2'd2;

    localparam logic [1:0] c_SRC_B_RS2  = 2'd0;
    localparam logic [1:0] c_SRC_B_IMM  = 2'd1;
    localparam logic [1:0] c_SRC_B_FOUR = 2'd2;

    localparam logic [1:0] c_WB_ALU = 2'd0;
    localparam logic [1:0] c_WB_MEM = 2'd1;
    localparam logic [1:0] c_WB_PC4 = 2'd2;

    // Shared by R-type and I-ALU; alt selects SUB/SRA
    function automatic logic [3:0] f_arith_op(input logic [2:0] func3, input logic alt);
        logic [3:0] op;
        case (func3)
            3'b000:  op = alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  op = c_ALU_SLL;
            3'b010:  op = c_ALU_SLT;
            3'b011:  op = c_ALU_SLTU;
            3'b100:  op = c_ALU_XOR;
            3'b101:  op = alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  op = c_ALU_OR;
            default: op = c_ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic f_is_legal(input logic [6:0] opcode, input logic [6:0] func7);
        logic ok;
        case (opcode)
            c_OP_RTYPE:  ok = (func7 == 7'b0000000) || (func7 == 7'b0100000);
            c_OP_IALU, c_OP_LOAD, c_OP_STORE, c_OP_BRANCH,
            c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR: ok = 1'b1;
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_unit_alu_op_decode.sv
//------------------------------------------------------------------------------
// alu_op_decode : maps (opcode, func3, func7[5]) to the ALU operation code
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_func3,
    input  logic       i_func7_b5,
    output logic [3:0] o_alu_op
);

    always_comb begin
        o_alu_op = c_ALU_ADD;
        case (i_opcode)
            c_OP_RTYPE: o_alu_op = f_arith_op(i_func3, i_func7_b5);
            // Immediate forms only carry a real func7 for the shift-right pair
            c_OP_IALU:  o_alu_op = f_arith_op(i_func3, i_func7_b5 && (i_func3 == 3'b101));
            c_OP_LUI:   o_alu_op = c_ALU_PASS_B;
            c_OP_BRANCH: begin
                case (i_func3[2:1])
                    2'b10:   o_alu_op = c_ALU_SLT;
                    2'b11:   o_alu_op = c_ALU_SLTU;
                    default: o_alu_op = c_ALU_SUB;
                endcase
            end
            default:    o_alu_op = c_ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
//------------------------------------------------------------------------------
// multicycle_control_unit : fetch/decode/execute/mem/wb sequencer for RV32I
// Revision                : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             instr_done,
    output logic [CNT_W-1:0] retire_count,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             mem_timeout
);

    localparam int c_WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [2:0]          r_state_q,   w_state_d;
    logic [c_WAIT_W-1:0] r_wait_q,    w_wait_d;
    logic [CNT_W-1:0]    r_retire_q,  w_retire_d;
    logic                r_illegal_q, w_illegal_d;
    logic                r_tmo_q,     w_tmo_d;

    logic       w_is_rtype, w_is_load, w_is_store, w_is_branch;
    logic       w_is_lui, w_is_auipc, w_is_jal, w_is_jalr;
    logic       w_mem_wait, w_tmo_hit, w_retire;
    logic [3:0] w_dec_alu_op;

    assign w_is_rtype  = (opcode == c_OP_RTYPE);
    assign w_is_load   = (opcode == c_OP_LOAD);
    assign w_is_store  = (opcode == c_OP_STORE);
    assign w_is_branch = (opcode == c_OP_BRANCH);
    assign w_is_lui    = (opcode == c_OP_LUI);
    assign w_is_auipc  = (opcode == c_OP_AUIPC);
    assign w_is_jal    = (opcode == c_OP_JAL);
    assign w_is_jalr   = (opcode == c_OP_JALR);

    // A response arriving on the limit cycle still completes the request
    assign w_mem_wait = ((r_state_q == c_ST_FETCH) || (r_state_q == c_ST_MEM)) && !mem_ready;
    assign w_tmo_hit  = (MEM_TIMEOUT != 0) && w_mem_wait &&
                        (r_wait_q == c_WAIT_W'(MEM_TIMEOUT - 1));

    alu_op_decode u_alu_op_decode (
        .i_opcode   (opcode),
        .i_func3    (func3),
        .i_func7_b5 (func7[5]),
        .o_alu_op   (w_dec_alu_op)
    );

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = c_PC_SRC_PC4;
        alu_src_a    = c_SRC_A_PC;
        alu_src_b    = c_SRC_B_RS2;
        alu_op       = c_ALU_ADD;
        reg_write    = 1'b0;
        wb_sel       = c_WB_ALU;
        w_retire     = 1'b0;
        case (r_state_q)
            c_ST_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
            end
            c_ST_EXECUTE: begin
                alu_op    = w_dec_alu_op;
                alu_src_a = w_is_lui ? c_SRC_A_ZERO :
                            (w_is_auipc || w_is_jal) ? c_SRC_A_PC : c_SRC_A_RS1;
                alu_src_b = (w_is_rtype || w_is_branch) ? c_SRC_B_RS2 : c_SRC_B_IMM;
                if (w_is_branch) begin
                    pc_write = 1'b1;
                    pc_src   = branch_taken ? c_PC_SRC_ALU : c_PC_SRC_PC4;
                    w_retire = 1'b1;
                end
            end
            c_ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = w_is_store;
                if (w_is_store && mem_ready) begin
                    pc_write = 1'b1;
                    w_retire = 1'b1;
                end
            end
            c_ST_WB: begin
                reg_write = 1'b1;
                wb_sel    = w_is_load ? c_WB_MEM :
                            (w_is_jal || w_is_jalr) ? c_WB_PC4 : c_WB_ALU;
                pc_write  = 1'b1;
                pc_src    = w_is_jal ? c_PC_SRC_ALU :
                            w_is_jalr ? c_PC_SRC_JALR : c_PC_SRC_PC4;
                w_retire  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_illegal_d = r_illegal_q;
        w_tmo_d     = r_tmo_q;
        w_retire_d  = r_retire_q;
        case (r_state_q)
            c_ST_IDLE:    if (run) w_state_d = c_ST_FETCH;
            c_ST_FETCH: begin
                if (mem_ready) begin
                    w_state_d = c_ST_DECODE;
                end else if (w_tmo_hit) begin
                    w_state_d = c_ST_HALT;
                    w_tmo_d   = 1'b1;
                end
            end
            c_ST_DECODE: begin
                if (!f_is_legal(opcode, func7)) begin
                    w_state_d   = c_ST_HALT;
                    w_illegal_d = 1'b1;
                end else begin
                    w_state_d = c_ST_EXECUTE;
                end
            end
            c_ST_EXECUTE: w_state_d = (w_is_load || w_is_store) ? c_ST_MEM : c_ST_WB;
            c_ST_MEM: begin
                if (mem_ready) begin
                    w_state_d = c_ST_WB;
                end else if (w_tmo_hit) begin
                    w_state_d = c_ST_HALT;
                    w_tmo_d   = 1'b1;
                end
            end
            c_ST_WB:      w_state_d = c_ST_WB;
            c_ST_HALT:    w_state_d = c_ST_HALT;
            default:      w_state_d = c_ST_IDLE;
        endcase
        // Retirement overrides the per-state successor
        if (w_retire) begin
            w_state_d  = run ? c_ST_FETCH : c_ST_IDLE;
            w_retire_d = r_retire_q + 1'b1;
        end
        w_wait_d = (w_mem_wait && (w_state_d == r_state_q)) ? r_wait_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q   <= c_ST_IDLE;
            r_wait_q    <= '0;
            r_retire_q  <= '0;
            r_illegal_q <= 1'b0;
            r_tmo_q     <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_wait_q    <= w_wait_d;
            r_retire_q  <= w_retire_d;
            r_illegal_q <= w_illegal_d;
            r_tmo_q     <= w_tmo_d;
        end
    end

    assign state        = r_state_q;
    assign retire_count = r_retire_q;
    assign illegal      = r_illegal_q;
    assign mem_timeout  = r_tmo_q;
    assign instr_done   = w_retire;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
//------------------------------------------------------------------------------
// tb_multicycle_control_unit : directed instruction sequences vs. phase model
// Revision                   : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_control_unit;

    localparam int TMO = 4;
    localparam int CW  = 3;

    logic          clk = 1'b0, rst_n = 1'b0, run = 1'b0;
    logic          branch_taken = 1'b0, mem_ready = 1'b0;
    logic [6:0]    opcode = '0, func7 = '0;
    logic [2:0]    func3 = '0;
    logic          mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, instr_done;
    logic [1:0]    pc_src, alu_src_a, alu_src_b, wb_sel;
    logic [3:0]    alu_op;
    logic [CW-1:0] retire_count;
    logic [2:0]    state;
    logic          illegal, mem_timeout;

    multicycle_control_unit #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .func3(func3), .func7(func7),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .wb_sel(wb_sel), .instr_done(instr_done), .retire_count(retire_count), .state(state),
        .illegal(illegal), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef enum int {K_R, K_I, K_LUI, K_AUIPC, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_ILL} kind_e;

    // One cycle of expected outputs plus the inputs applied in that cycle
    typedef struct packed {
        logic [2:0]    st;
        logic          mreq, mwe, masel, irw, pcw;
        logic [1:0]    pcs, sa, sb;
        logic [3:0]    aop;
        logic          rw;
        logic [1:0]    wbs;
        logic          done, set_ill, set_tmo;
        logic          in_ready, in_run;
        logic          pin_en;
        logic [CW-1:0] pin_cnt;
        logic [1:0]    pin_flags;
    } rec_t;

    rec_t          cur;
    logic          cur_valid = 1'b0;
    logic          pend_en = 1'b0;
    logic [CW-1:0] pend_cnt = '0;
    logic [1:0]    pend_flags = '0;
    logic [CW-1:0] m_cnt = '0;
    logic          m_ill = 1'b0, m_tmo = 1'b0;
    int            total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cur_valid) begin
            if (!rst_n) begin
                m_cnt = '0;
                m_ill = 1'b0;
                m_tmo = 1'b0;
            end
            chk("state", 32'(state), 32'(cur.st));
            chk("mem_req", 32'(mem_req), 32'(cur.mreq));
            chk("mem_we", 32'(mem_we), 32'(cur.mwe));
            chk("mem_addr_sel", 32'(mem_addr_sel), 32'(cur.masel));
            chk("ir_write", 32'(ir_write), 32'(cur.irw));
            chk("pc_write", 32'(pc_write), 32'(cur.pcw));
            chk("pc_src", 32'(pc_src), 32'(cur.pcs));
            chk("alu_src_a", 32'(alu_src_a), 32'(cur.sa));
            chk("alu_src_b", 32'(alu_src_b), 32'(cur.sb));
            chk("alu_op", 32'(alu_op), 32'(cur.aop));
            chk("reg_write", 32'(reg_write), 32'(cur.rw));
            chk("wb_sel", 32'(wb_sel), 32'(cur.wbs));
            chk("instr_done", 32'(instr_done), 32'(cur.done));
            chk("retire_count", 32'(retire_count), 32'(m_cnt));
            chk("illegal", 32'(illegal), 32'(m_ill));
            chk("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
            if (cur.pin_en) begin
                chk("pin_count", 32'(retire_count), 32'(cur.pin_cnt));
                chk("pin_model_count", 32'(m_cnt), 32'(cur.pin_cnt));
                chk("pin_flags", 32'({illegal, mem_timeout}), 32'(cur.pin_flags));
            end
            if (cur.done)    m_cnt = m_cnt + 1'b1;
            if (cur.set_ill) m_ill = 1'b1;
            if (cur.set_tmo) m_tmo = 1'b1;
        end
    end

    function automatic rec_t blank(input logic [2:0] s);
        rec_t e;
        e          = '0;
        e.st       = s;
        e.in_ready = 1'b1;
        return e;
    endfunction

    task automatic play(input rec_t e);
        if (pend_en) begin
            e.pin_en    = 1'b1;
            e.pin_cnt   = pend_cnt;
            e.pin_flags = pend_flags;
            pend_en     = 1'b0;
        end
        mem_ready = e.in_ready;
        run       = e.in_run;
        cur       = e;
        cur_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input logic [CW-1:0] c, input logic [1:0] f);
        pend_en    = 1'b1;
        pend_cnt   = c;
        pend_flags = f;
    endtask

    task automatic idle(input logic r);
        rec_t e;
        e        = blank(3'd0);
        e.in_run = r;
        play(e);
    endtask

    task automatic halt_cycles(input int n);
        rec_t e;
        for (int i = 0; i < n; i++) begin
            e        = blank(3'd6);
            e.in_run = 1'b1;
            play(e);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        play(blank(3'd0));
        rst_n = 1'b1;
    endtask

    // Expands one instruction into its phase sequence with stall counts fw/mw
    task automatic do_instr(input logic [31:0] ins, input kind_e k, input logic [3:0] aop,
                            input logic tk, input int fw, input int mw,
                            input logic rn, input logic abort);
        rec_t e;
        opcode       = ins[6:0];
        func3        = ins[14:12];
        func7        = ins[31:25];
        branch_taken = tk;
        for (int i = 0; i < fw; i++) begin
            e          = blank(3'd1);
            e.mreq     = 1'b1;
            e.in_ready = 1'b0;
            if (i == TMO - 1) begin
                e.set_tmo = 1'b1;
                play(e);
                halt_cycles(2);
                return;
            end
            play(e);
        end
        e      = blank(3'd1);
        e.mreq = 1'b1;
        e.irw  = 1'b1;
        play(e);
        e = blank(3'd2);
        if (k == K_ILL) begin
            e.set_ill = 1'b1;
            play(e);
            halt_cycles(2);
            return;
        end
        play(e);
        e     = blank(3'd3);
        e.aop = aop;
        e.sa  = (k == K_LUI) ? 2'd2 : (k == K_AUIPC || k == K_JAL) ? 2'd0 : 2'd1;
        e.sb  = (k == K_R || k == K_BR) ? 2'd0 : 2'd1;
        if (k == K_BR) begin
            e.pcw    = 1'b1;
            e.pcs    = tk ? 2'd1 : 2'd0;
            e.done   = 1'b1;
            e.in_run = rn;
            play(e);
            return;
        end
        play(e);
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < mw; i++) begin
                e          = blank(3'd4);
                e.mreq     = 1'b1;
                e.masel    = 1'b1;
                e.mwe      = (k == K_ST);
                e.in_ready = 1'b0;
                if (i == TMO - 1) begin
                    e.set_tmo = 1'b1;
                    play(e);
                    halt_cycles(2);
                    return;
                end
                play(e);
            end
            if (abort) return;
            e       = blank(3'd4);
            e.mreq  = 1'b1;
            e.masel = 1'b1;
            e.mwe   = (k == K_ST);
            if (k == K_ST) begin
                e.pcw    = 1'b1;
                e.done   = 1'b1;
                e.in_run = rn;
                play(e);
                return;
            end
            play(e);
        end
        e        = blank(3'd5);
        e.rw     = 1'b1;
        e.wbs    = (k == K_LD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0;
        e.pcw    = 1'b1;
        e.pcs    = (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
        e.done   = 1'b1;
        e.in_run = rn;
        play(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        play(blank(3'd0));
        play(blank(3'd0));
        rst_n = 1'b1;
        idle(1'b1);
        do_instr(32'h00C585B3, K_R,     4'd0,  1'b0, 0, 0, 1'b1, 1'b0);
        pin(3'd1, 2'b00);
        do_instr(32'h0041A583, K_LD,    4'd0,  1'b0, 1, 3, 1'b1, 1'b0);
        do_instr(32'h00B50663, K_BR,    4'd1,  1'b1, 0, 0, 1'b1, 1'b0);
        do_instr(32'h00B50663, K_BR,    4'd1,  1'b0, 0, 0, 1'b1, 1'b0);
        do_instr(32'h004000EF, K_JAL,   4'd0,  1'b0, 0, 0, 1'b1, 1'b0);
        do_instr(32'h00B12223, K_ST,    4'd0,  1'b0, 0, 1, 1'b1, 1'b0);
        do_instr(32'h40B50533, K_R,     4'd1,  1'b0, 3, 0, 1'b1, 1'b0);
        do_instr(32'h4030D093, K_I,     4'd7,  1'b0, 0, 0, 1'b1, 1'b0);
        do_instr(32'h40000093, K_I,     4'd0,  1'b0, 0, 0, 1'b1, 1'b0);
        pin(3'd1, 2'b00);
        do_instr(32'h123450B7, K_LUI,   4'd10, 1'b0, 0, 0, 1'b1, 1'b0);
        do_instr(32'h00001097, K_AUIPC, 4'd0,  1'b0, 0, 0, 1'b1, 1'b0);
        do_instr(32'h000080E7, K_JALR,  4'd0,  1'b0, 0, 0, 1'b1, 1'b0);
        do_instr(32'h00B56663, K_BR,    4'd4,  1'b1, 0, 0, 1'b1, 1'b0);
        do_instr(32'h00B54663, K_BR,    4'd3,  1'b0, 0, 0, 1'b0, 1'b0);
        pin(3'd6, 2'b00);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        do_instr(32'h0000007F, K_ILL,   4'd0,  1'b0, 0, 0, 1'b1, 1'b0);
        pin(3'd6, 2'b10);
        halt_cycles(1);
        do_reset();
        idle(1'b1);
        do_instr(32'h00C585B3, K_R,     4'd0,  1'b0, 4, 0, 1'b1, 1'b0);
        pin(3'd0, 2'b01);
        halt_cycles(1);
        do_reset();
        idle(1'b1);
        do_instr(32'h0041A583, K_LD,    4'd0,  1'b0, 0, 4, 1'b1, 1'b0);
        pin(3'd0, 2'b01);
        halt_cycles(1);
        do_reset();
        idle(1'b1);
        do_instr(32'h02B50533, K_ILL,   4'd0,  1'b0, 0, 0, 1'b1, 1'b0);
        do_reset();
        idle(1'b1);
        do_instr(32'h00C585B3, K_R,     4'd0,  1'b0, 0, 0, 1'b1, 1'b0);
        do_instr(32'h0041A583, K_LD,    4'd0,  1'b0, 0, 2, 1'b1, 1'b1);
        rst_n      = 1'b0;
        e          = blank(3'd0);
        e.in_ready = 1'b0;
        pin(3'd0, 2'b00);
        play(e);
        rst_n = 1'b1;
        idle(1'b1);
        do_instr(32'h00C585B3, K_R,     4'd0,  1'b0, 0, 0, 1'b0, 1'b0);
        pin(3'd1, 2'b00);
        idle(1'b0);
        cur_valid = 1'b0;
        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
